// File: rtl/sev_segm2byte_if.sv
// sev_segm2byte_if: segment-stream input and decoded-byte output bundle.
//   i_segm        : active-low segment pattern, bit6=g .. bit0=a
//   i_segm_strobe : i_segm / i_digit_sel valid this cycle
//   i_digit_sel   : 0 = low digit, 1 = high digit
//   o_byte        : last published byte
//   o_byte_valid  : one-cycle pulse when o_byte is updated
//   o_pattern_err : one-cycle pulse, frame discarded (bad pattern / digit >= radix)
//   o_seq_err     : one-cycle pulse, digit order violated
// master = stimulus side, slave = decoder side.
interface sev_segm2byte_if;
    logic [6:0] i_segm;
    logic       i_segm_strobe;
    logic       i_digit_sel;
    logic [7:0] o_byte;
    logic       o_byte_valid;
    logic       o_pattern_err;
    logic       o_seq_err;

    modport master (
        output i_segm, i_segm_strobe, i_digit_sel,
        input  o_byte, o_byte_valid, o_pattern_err, o_seq_err
    );

    modport slave (
        input  i_segm, i_segm_strobe, i_digit_sel,
        output o_byte, o_byte_valid, o_pattern_err, o_seq_err
    );
endinterface

// File: rtl/sev_segm2byte.sv
// sev_segm2byte: decodes a strobed stream of seven-segment digit patterns
// (low digit, then high digit) back into a byte and publishes the byte once
// the same valid frame has been received STABLE consecutive times.
// Ports:
//   i_clk : clock, all logic on the rising edge
//   i_rst : synchronous active-high reset
//   i_bus : sev_segm2byte_if slave modport (segment input, byte/error outputs)
module sev_segm2byte #(
    parameter int NOTATION = 16,  // digit radix, 2..16
    parameter int STABLE   = 2    // identical frames before publishing, 1..15
) (
    input  logic          i_clk,
    input  logic          i_rst,
    sev_segm2byte_if.slave i_bus
);

    localparam logic [4:0] NOT5 = 5'(NOTATION);
    localparam logic [7:0] NOT8 = 8'(NOTATION);
    localparam logic [3:0] STB  = 4'(STABLE);

    typedef enum logic {WAIT_LO, WAIT_HI} state_t;

    state_t     r_state;
    logic [3:0] r_lo;
    logic       r_lo_bad;
    logic [7:0] r_cand;
    logic [3:0] r_count;
    logic [7:0] r_byte;
    logic       r_byte_valid;
    logic       r_pattern_err;
    logic       r_seq_err;

    logic [3:0] w_dig;
    logic       w_pat_ok;
    logic       w_dig_ok;
    logic [7:0] w_value;

    // Active-low pattern decode; anything outside the table (blank included) is invalid.
    always_comb begin
        w_dig    = '0;
        w_pat_ok = 1'b1;
        case (i_bus.i_segm)
            7'b1000000: w_dig = 4'h0;
            7'b1111001: w_dig = 4'h1;
            7'b0100100: w_dig = 4'h2;
            7'b0110000: w_dig = 4'h3;
            7'b0011001: w_dig = 4'h4;
            7'b0010010: w_dig = 4'h5;
            7'b0000010: w_dig = 4'h6;
            7'b1111000: w_dig = 4'h7;
            7'b0000000: w_dig = 4'h8;
            7'b0010000: w_dig = 4'h9;
            7'b0001000: w_dig = 4'hA;
            7'b0000011: w_dig = 4'hB;
            7'b1000110: w_dig = 4'hC;
            7'b0100001: w_dig = 4'hD;
            7'b0000110: w_dig = 4'hE;
            7'b0001110: w_dig = 4'hF;
            default:    w_pat_ok = 1'b0;
        endcase
    end

    assign w_dig_ok = w_pat_ok && ({1'b0, w_dig} < NOT5);
    // Current digit is the high digit whenever this value is consumed.
    assign w_value  = {4'b0000, w_dig} * NOT8 + {4'b0000, r_lo};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= WAIT_LO;
            r_lo          <= '0;
            r_lo_bad      <= 1'b0;
            r_cand        <= '0;
            r_count       <= '0;
            r_byte        <= '0;
            r_byte_valid  <= 1'b0;
            r_pattern_err <= 1'b0;
            r_seq_err     <= 1'b0;
        end else begin
            r_byte_valid  <= 1'b0;
            r_pattern_err <= 1'b0;
            r_seq_err     <= 1'b0;
            if (i_bus.i_segm_strobe) begin
                case (r_state)
                    WAIT_LO: begin
                        if (!i_bus.i_digit_sel) begin
                            r_lo     <= w_dig;
                            r_lo_bad <= !w_dig_ok;
                            r_state  <= WAIT_HI;
                        end else begin
                            r_seq_err <= 1'b1;
                        end
                    end
                    WAIT_HI: begin
                        if (!i_bus.i_digit_sel) begin
                            // Repeated low digit: newest one wins.
                            r_lo      <= w_dig;
                            r_lo_bad  <= !w_dig_ok;
                            r_seq_err <= 1'b1;
                        end else begin
                            r_state <= WAIT_LO;
                            if (r_lo_bad || !w_dig_ok) begin
                                r_pattern_err <= 1'b1;
                                r_count       <= '0;
                            end else if (w_value == r_cand && r_count != '0) begin
                                // Saturates at STB, so publish fires only on the transition.
                                if (r_count != STB) begin
                                    r_count <= r_count + 4'd1;
                                    if (r_count + 4'd1 == STB) begin
                                        r_byte       <= w_value;
                                        r_byte_valid <= 1'b1;
                                    end
                                end
                            end else begin
                                r_cand  <= w_value;
                                r_count <= 4'd1;
                                if (STB == 4'd1) begin
                                    r_byte       <= w_value;
                                    r_byte_valid <= 1'b1;
                                end
                            end
                        end
                    end
                    default: r_state <= WAIT_LO;
                endcase
            end
        end
    end

    assign i_bus.o_byte        = r_byte;
    assign i_bus.o_byte_valid  = r_byte_valid;
    assign i_bus.o_pattern_err = r_pattern_err;
    assign i_bus.o_seq_err     = r_seq_err;

endmodule

// File: tb/tb_sev_segm2byte.sv
// tb_sev_segm2byte: directed scoreboard bench for sev_segm2byte.
// DUT0: NOTATION=16 STABLE=2, DUT1: NOTATION=10 STABLE=2, DUT2: NOTATION=16 STABLE=1.
module tb_sev_segm2byte;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [6:0] segm   [3];
    logic       strobe [3];
    logic       sel    [3];
    logic [7:0] ob     [3];
    logic       obv    [3];
    logic       ope    [3];
    logic       ose    [3];

    sev_segm2byte_if if0 ();
    sev_segm2byte_if if1 ();
    sev_segm2byte_if if2 ();

    assign if0.i_segm = segm[0]; assign if0.i_segm_strobe = strobe[0]; assign if0.i_digit_sel = sel[0];
    assign if1.i_segm = segm[1]; assign if1.i_segm_strobe = strobe[1]; assign if1.i_digit_sel = sel[1];
    assign if2.i_segm = segm[2]; assign if2.i_segm_strobe = strobe[2]; assign if2.i_digit_sel = sel[2];
    assign ob[0] = if0.o_byte; assign obv[0] = if0.o_byte_valid; assign ope[0] = if0.o_pattern_err; assign ose[0] = if0.o_seq_err;
    assign ob[1] = if1.o_byte; assign obv[1] = if1.o_byte_valid; assign ope[1] = if1.o_pattern_err; assign ose[1] = if1.o_seq_err;
    assign ob[2] = if2.o_byte; assign obv[2] = if2.o_byte_valid; assign ope[2] = if2.o_pattern_err; assign ose[2] = if2.o_seq_err;

    sev_segm2byte #(.NOTATION(16), .STABLE(2)) u_dut0 (.i_clk(clk), .i_rst(rst), .i_bus(if0.slave));
    sev_segm2byte #(.NOTATION(10), .STABLE(2)) u_dut1 (.i_clk(clk), .i_rst(rst), .i_bus(if1.slave));
    sev_segm2byte #(.NOTATION(16), .STABLE(1)) u_dut2 (.i_clk(clk), .i_rst(rst), .i_bus(if2.slave));

    // Expected {byte_valid, byte, pattern_err, seq_err} for one DUT after one edge.
    typedef struct {
        int          d;
        logic [10:0] e;
        string       tag;
    } item_t;
    item_t sbq[$];

    int vecs = 0;
    int miscmp = 0;

    logic [6:0] P [16];
    localparam logic [6:0] BLANK = 7'b1111111;

    task automatic check_one();
        item_t       it;
        logic [10:0] got;
        it  = sbq.pop_front();
        got = {obv[it.d], ob[it.d], ope[it.d], ose[it.d]};
        vecs++;
        assert (got === it.e) else begin
            miscmp++;
            $error("FAIL %s dut%0d: got v=%b byte=%h perr=%b serr=%b, expected v=%b byte=%h perr=%b serr=%b",
                   it.tag, it.d, got[10], got[9:2], got[1], got[0],
                   it.e[10], it.e[9:2], it.e[1], it.e[0]);
        end
    endtask

    task automatic step(input int d, input logic stb, input logic s, input logic [6:0] seg,
                        input logic v, input logic [7:0] b, input logic pe, input logic se,
                        input string tag);
        for (int k = 0; k < 3; k++) strobe[k] = 1'b0;
        strobe[d] = stb;
        sel[d]    = s;
        segm[d]   = seg;
        sbq.push_back('{d, {v, b, pe, se}, tag});
        @(posedge clk);
        #1;
        check_one();
    endtask

    task automatic do_reset(input logic [7:0] b0, input string tag);
        for (int k = 0; k < 3; k++) strobe[k] = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sbq.push_back('{k, {1'b0, b0, 1'b0, 1'b0}, tag});
            check_one();
        end
    endtask

    initial begin
        P[0]  = 7'b1000000; P[1]  = 7'b1111001; P[2]  = 7'b0100100; P[3]  = 7'b0110000;
        P[4]  = 7'b0011001; P[5]  = 7'b0010010; P[6]  = 7'b0000010; P[7]  = 7'b1111000;
        P[8]  = 7'b0000000; P[9]  = 7'b0010000; P[10] = 7'b0001000; P[11] = 7'b0000011;
        P[12] = 7'b1000110; P[13] = 7'b0100001; P[14] = 7'b0000110; P[15] = 7'b0001110;
        for (int k = 0; k < 3; k++) begin
            segm[k] = BLANK; strobe[k] = 1'b0; sel[k] = 1'b0;
        end
        @(posedge clk);
        do_reset(8'h00, "reset");

        // DUT0: 0xA5 twice, back-to-back strobes
        step(0, 1, 0, P[5],  0, 8'h00, 0, 0, "a5_lo1");
        step(0, 1, 1, P[10], 0, 8'h00, 0, 0, "a5_hi1");
        step(0, 1, 0, P[5],  0, 8'h00, 0, 0, "a5_lo2");
        step(0, 1, 1, P[10], 1, 8'hA5, 0, 0, "a5_pub");
        step(0, 0, 0, BLANK, 0, 8'hA5, 0, 0, "a5_pulse1cyc");
        // third identical frame: saturated, no pulse
        step(0, 1, 0, P[5],  0, 8'hA5, 0, 0, "a5_lo3");
        step(0, 1, 1, P[10], 0, 8'hA5, 0, 0, "a5_sat");
        // 0x3C twice
        step(0, 1, 0, P[12], 0, 8'hA5, 0, 0, "3c_lo1");
        step(0, 1, 1, P[3],  0, 8'hA5, 0, 0, "3c_hi1");
        step(0, 1, 0, P[12], 0, 8'hA5, 0, 0, "3c_lo2");
        step(0, 1, 1, P[3],  1, 8'h3C, 0, 0, "3c_pub");
        // idle: state holds, no pulses
        step(0, 0, 0, BLANK, 0, 8'h3C, 0, 0, "idle1");
        step(0, 0, 0, BLANK, 0, 8'h3C, 0, 0, "idle2");
        // blank low digit
        step(0, 1, 0, BLANK, 0, 8'h3C, 0, 0, "blank_lo");
        step(0, 1, 1, P[3],  0, 8'h3C, 1, 0, "blank_perr");
        // hi strobe in WAIT_LO
        step(0, 1, 1, P[3],  0, 8'h3C, 0, 1, "hi_in_wait_lo");
        // lo=1, lo=2, hi=0 -> frame 0x02
        step(0, 1, 0, P[1],  0, 8'h3C, 0, 0, "dup_lo1");
        step(0, 1, 0, P[2],  0, 8'h3C, 0, 1, "dup_lo2");
        step(0, 1, 1, P[0],  0, 8'h3C, 0, 0, "dup_hi");
        step(0, 1, 0, P[2],  0, 8'h3C, 0, 0, "02_lo");
        step(0, 1, 1, P[0],  1, 8'h02, 0, 0, "02_pub");
        // earlier published value restarts and republishes
        step(0, 1, 0, P[12], 0, 8'h02, 0, 0, "3cr_lo1");
        step(0, 1, 1, P[3],  0, 8'h02, 0, 0, "3cr_hi1");
        step(0, 1, 0, P[12], 0, 8'h02, 0, 0, "3cr_lo2");
        step(0, 1, 1, P[3],  1, 8'h3C, 0, 0, "3cr_pub");

        // DUT1 (radix 10): hi digit A is out of range
        step(1, 1, 0, P[5],  0, 8'h00, 0, 0, "n10_lo");
        step(1, 1, 1, P[10], 0, 8'h00, 1, 0, "n10_perr");
        step(1, 1, 0, P[9],  0, 8'h00, 0, 0, "n10_99_lo1");
        step(1, 1, 1, P[9],  0, 8'h00, 0, 0, "n10_99_hi1");
        step(1, 1, 0, P[9],  0, 8'h00, 0, 0, "n10_99_lo2");
        step(1, 1, 1, P[9],  1, 8'd99, 0, 0, "n10_99_pub");
        // low digit out of range too
        step(1, 1, 0, P[11], 0, 8'd99, 0, 0, "n10_lo_b");
        step(1, 1, 1, P[1],  0, 8'd99, 1, 0, "n10_lo_perr");

        // DUT2 (STABLE=1): first valid frame publishes, repeat does not
        step(2, 1, 0, P[5],  0, 8'h00, 0, 0, "s1_lo1");
        step(2, 1, 1, P[10], 1, 8'hA5, 0, 0, "s1_pub");
        step(2, 1, 0, P[5],  0, 8'hA5, 0, 0, "s1_lo2");
        step(2, 1, 1, P[10], 0, 8'hA5, 0, 0, "s1_sat");
        step(2, 1, 0, P[15], 0, 8'hA5, 0, 0, "s1_ff_lo");
        step(2, 1, 1, P[15], 1, 8'hFF, 0, 0, "s1_ff_pub");

        // reset mid-frame on DUT0
        step(0, 1, 0, P[7],  0, 8'h3C, 0, 0, "rst_lo7");
        do_reset(8'h00, "rst_mid");
        step(0, 1, 1, P[7],  0, 8'h00, 0, 1, "rst_hi7");
        step(0, 0, 0, BLANK, 0, 8'h00, 0, 0, "rst_idle");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end

endmodule

// File: doc/sev_segm2byte.md
Name: sev_segm2byte

Overview:
- Receive-side counterpart of the byte-to-seven-segment encoder.
- Samples a strobed stream of seven-segment digit patterns (low digit, then high digit) and decodes each pattern back to its digit value.
- Reassembles the byte and publishes it only after the same frame has been seen STABLE consecutive times.
- Used to check display outputs in loopback and to read segment buses from external boards.

Parameters:
- NOTATION, 16, radix of the digits; legal 2..16; byte = hi*NOTATION + lo.
- STABLE, 2, consecutive identical valid frames required before publishing; legal 1..15.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- segm  in  7  active-low segment pattern, bit6=g .. bit0=a.
- segm_strobe  in  1  segm/digit_sel valid this cycle.
- digit_sel  in  1  0 = low digit (segm0), 1 = high digit (segm1).
- byte  out  8  last published value.
- byte_valid  out  1  one-cycle pulse when byte is updated.
- pattern_err  out  1  one-cycle pulse: frame discarded for bad pattern or digit >= NOTATION.
- seq_err  out  1  one-cycle pulse: digit order violated.

Behaviour:
- Decode table (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- Digit is invalid if:
  - its pattern is not in the table (including blank 1111111), or
  - its decoded value >= NOTATION.
- Reset (rst=1 at a clock edge) sets:
  - state=WAIT_LO, lo/candidate/count=0.
  - byte=8'h00, byte_valid=0, pattern_err=0, seq_err=0.
  - Reset mid-frame discards the partial frame.
- FSM WAIT_LO:
  - strobe & sel=0: latch decoded lo and its invalid flag; go to WAIT_HI.
  - strobe & sel=1: seq_err pulse; stay in WAIT_LO; count unchanged.
- FSM WAIT_HI:
  - strobe & sel=1: frame complete; go to WAIT_LO.
  - strobe & sel=0: seq_err pulse; replace lo with the new digit; stay in WAIT_HI.
- No strobe: state holds indefinitely; there is no timeout.
- On frame complete:
  - If either digit is invalid: pattern_err pulse; count=0; candidate unchanged.
  - Else value = hi*NOTATION + lo, computed 8 bits wide (max 255 at NOTATION=16).
  - If value == candidate and count != 0: count = min(count+1, STABLE).
  - Otherwise: candidate=value, count=1.
- Publish:
  - Fires when count transitions to exactly STABLE (including 0->1 when STABLE=1).
  - byte=candidate and byte_valid=1 in the cycle after the completing strobe edge.
  - Latency is 1 cycle from the completing strobe.
  - Further identical frames with count saturated: no pulse, byte held.
- A different valid value restarts the count. It is republished after STABLE frames, even if it equals an earlier published value.
- Error outputs: pattern_err and seq_err are registered and asserted in the cycle after the offending strobe.
- All pulses are exactly one cycle wide; outputs not pulsing are 0.

Test Plan:
- NOTATION=16, STABLE=2; after reset send frame (lo=0010010, hi=0001000) twice, strobes back-to-back -> byte_valid for 1 cycle after the 4th strobe, byte=8'hA5; no pulse after the 2nd strobe.
- Continue with a 3rd identical frame -> no byte_valid, byte stays 8'hA5; then frame 0x3C twice -> byte=8'h3C, single pulse.
- NOTATION=10; send hi pattern 0001000 (A) -> pattern_err pulse; count cleared; next frames lo=9, hi=9 (0010000) x2 -> byte=8'd99.
- Blank pattern 1111111 as lo -> pattern_err on frame completion; byte unchanged.
- Sequence errors:
  - hi strobe in WAIT_LO -> seq_err, no state change.
  - lo=1 then lo=2 then hi=0 -> one seq_err; frame decoded as 0x02.
- Send lo=7, assert rst for 1 cycle, then send hi=7 -> seq_err (treated as out-of-order hi); all outputs 0 immediately after reset; byte=8'h00.
